// File: rtl/beacon_tbtt_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beacon_tbtt_scheduler_pkg
// Description : Shared xpu definitions for the beacon TBTT scheduler: FSM
//               state encoding, default timer width and a saturating
//               increment helper for the statistic counters.
// Revision    : 1.0 - initial release
// ============================================================================
package beacon_tbtt_scheduler_pkg;

    localparam int TIMER_WIDTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TBTT = 2'd1,
        WAIT_SENT = 2'd2,
        CATCHUP   = 2'd3
    } bcn_state_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beacon_tbtt_scheduler_tbtt_lead_calc.sv
`default_nettype none
// ============================================================================
// Module      : beacon_tbtt_scheduler_tbtt_lead_calc
// Description : Registers the beacon lead time (processing delay + guard,
//               saturated to one below the beacon interval) and the fire
//               compare tsf + lead >= target.
// Ports       : clk, rstn          - clock, synchronous active-low reset
//               arm                - compare is only meaningful while set
//               bcn_interval       - beacon period (us), saturation bound
//               guard_us           - extra lead margin (us)
//               prosessing_delay   - measured start-to-sent delay (us)
//               tsf                - running TSF
//               target             - TBTT being chased
//               fire               - registered compare result
// Revision    : 1.0 - initial release
// ============================================================================
module beacon_tbtt_scheduler_tbtt_lead_calc #(
    parameter int TIMER_WIDTH    = 64,
    parameter int INTERVAL_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      arm,
    input  logic [INTERVAL_WIDTH-1:0] bcn_interval,
    input  logic [15:0]               guard_us,
    input  logic [TIMER_WIDTH-1:0]    prosessing_delay,
    input  logic [TIMER_WIDTH-1:0]    tsf,
    input  logic [TIMER_WIDTH-1:0]    target,
    output logic                      fire
);

    // One extra bit so neither the lead sum nor tsf + lead can overflow.
    localparam int SUM_W = TIMER_WIDTH + 1;

    logic [SUM_W-1:0]          lead_sum;
    logic [INTERVAL_WIDTH-1:0] lead_next;
    logic [INTERVAL_WIDTH-1:0] lead;
    logic                      reach;

    assign lead_sum = {1'b0, prosessing_delay} + SUM_W'(guard_us);

    always_comb begin
        lead_next = '0;
        if (bcn_interval == '0) begin
            lead_next = '0;
        end else if (lead_sum >= SUM_W'(bcn_interval)) begin
            lead_next = bcn_interval - 1'b1;
        end else begin
            lead_next = lead_sum[INTERVAL_WIDTH-1:0];
        end
    end

    assign reach = ({1'b0, tsf} + SUM_W'(lead)) >= {1'b0, target};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lead <= '0;
            fire <= 1'b0;
        end else begin
            lead <= lead_next;
            fire <= arm & reach;
        end
    end

endmodule
`default_nettype wire

// File: rtl/beacon_tbtt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : beacon_tbtt_scheduler
// Description : Schedules AP beacon transmission against the TSF. Tracks the
//               next TBTT, fires start_beaconing early by the lead time so
//               the beacon reaches air at TBTT, waits for sent_beacon or a
//               timeout, then advances. Late TBTTs are skipped in CATCHUP.
// Ports       : clk, rstn        - clock, synchronous active-low reset
//               enable           - beaconing active
//               bcn_interval     - beacon period (us), 0 is invalid
//               guard_us         - extra lead margin (us)
//               timeout_us       - max wait for sent_beacon (us)
//               tsf_runtime_val  - free-running TSF, +1 per us
//               prosessing_delay - last measured start-to-sent delay
//               sent_beacon      - beacon finished on air (pulse)
//               start_beaconing  - launch pulse
//               beacon_busy      - start pulse until sent/timeout
//               next_tbtt        - currently targeted TBTT
//               sent_count       - completed beacons (saturating)
//               missed_count     - skipped/timed-out TBTTs (saturating)
//               cfg_err          - sticky: enabled with zero interval
// Revision    : 1.0 - initial release
// ============================================================================
module beacon_tbtt_scheduler
    import beacon_tbtt_scheduler_pkg::*;
#(
    parameter int TIMER_WIDTH    = TIMER_WIDTH_DEFAULT,
    parameter int INTERVAL_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic [INTERVAL_WIDTH-1:0] bcn_interval,
    input  logic [15:0]               guard_us,
    input  logic [15:0]               timeout_us,
    input  logic [TIMER_WIDTH-1:0]    tsf_runtime_val,
    input  logic [TIMER_WIDTH-1:0]    prosessing_delay,
    input  logic                      sent_beacon,
    output logic                      start_beaconing,
    output logic                      beacon_busy,
    output logic [TIMER_WIDTH-1:0]    next_tbtt,
    output logic [CNT_WIDTH-1:0]      sent_count,
    output logic [CNT_WIDTH-1:0]      missed_count,
    output logic                      cfg_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    bcn_state_t             state;
    logic [TIMER_WIDTH-1:0] start_tsf;
    logic                   fire;
    logic                   late;
    logic                   timed_out;
    logic                   interval_ok;
    logic [TIMER_WIDTH-1:0] interval_ext;

    assign interval_ok  = (bcn_interval != '0);
    assign interval_ext = TIMER_WIDTH'(bcn_interval);
    assign late         = (tsf_runtime_val >= next_tbtt);
    assign timed_out    = ({1'b0, tsf_runtime_val} >=
                           ({1'b0, start_tsf} + (TIMER_WIDTH + 1)'(timeout_us)));

    // The compare is armed only while the FSM already sits in WAIT_TBTT, so a
    // fire computed against a stale next_tbtt never survives into the state.
    beacon_tbtt_scheduler_tbtt_lead_calc #(
        .TIMER_WIDTH    (TIMER_WIDTH),
        .INTERVAL_WIDTH (INTERVAL_WIDTH)
    ) u_lead_calc (
        .clk              (clk),
        .rstn             (rstn),
        .arm              (state == WAIT_TBTT),
        .bcn_interval     (bcn_interval),
        .guard_us         (guard_us),
        .prosessing_delay (prosessing_delay),
        .tsf              (tsf_runtime_val),
        .target           (next_tbtt),
        .fire             (fire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            start_tsf       <= '0;
            start_beaconing <= 1'b0;
            beacon_busy     <= 1'b0;
            next_tbtt       <= '0;
            sent_count      <= '0;
            missed_count    <= '0;
            cfg_err         <= 1'b0;
        end else begin
            start_beaconing <= 1'b0;

            if (enable && !interval_ok) begin
                cfg_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable && interval_ok) begin
                        next_tbtt <= tsf_runtime_val + interval_ext;
                        state     <= WAIT_TBTT;
                    end
                end

                WAIT_TBTT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (late) begin
                        state <= CATCHUP;
                    end else if (fire) begin
                        start_beaconing <= 1'b1;
                        start_tsf       <= tsf_runtime_val;
                        beacon_busy     <= 1'b1;
                        state           <= WAIT_SENT;
                    end
                end

                WAIT_SENT: begin
                    // sent_beacon takes priority over a coincident timeout.
                    if (sent_beacon || timed_out) begin
                        if (sent_beacon) begin
                            sent_count <= CNT_WIDTH'(sat_inc(64'(sent_count), 64'(CNT_MAX)));
                        end else begin
                            missed_count <= CNT_WIDTH'(sat_inc(64'(missed_count), 64'(CNT_MAX)));
                        end
                        beacon_busy <= 1'b0;
                        if (!interval_ok) begin
                            state <= IDLE;
                        end else begin
                            next_tbtt <= next_tbtt + interval_ext;
                            state     <= enable ? WAIT_TBTT : IDLE;
                        end
                    end
                end

                CATCHUP: begin
                    if (!enable || !interval_ok) begin
                        state <= IDLE;
                    end else if (next_tbtt > tsf_runtime_val) begin
                        state <= WAIT_TBTT;
                    end else begin
                        next_tbtt    <= next_tbtt + interval_ext;
                        missed_count <= CNT_WIDTH'(sat_inc(64'(missed_count), 64'(CNT_MAX)));
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
